// File: rtl/mac_seq_ctrl.sv
// Sequencer that streams a NUM_ROWS x VEC_S matrix, vector and bias into an external MAC
// and writes one result per row, tracking per-row and per-job overflow.
module mac_seq_ctrl #(
  parameter int NUM_S    = 1,
  parameter int VEC_S    = 4,
  parameter int NUM_ROWS = 4,
  localparam int MAW     = $clog2(NUM_ROWS * VEC_S),
  localparam int VAW     = $clog2(VEC_S),
  localparam int RAW     = $clog2(NUM_ROWS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [MAW-1:0]         m_addr,
  input  logic signed [7:0]      m_data,
  output logic [VAW-1:0]         v_addr,
  input  logic signed [7:0]      v_data,
  output logic [RAW-1:0]         bias_addr,
  input  logic [7:0]             bias_data,
  output logic signed [7:0]      mac_a,
  output logic signed [7:0]      mac_b,
  output logic [7:0]             mac_x,
  output logic                   mac_valid_in,
  input  logic signed [15:0]     mac_f,
  input  logic                   mac_valid_out,
  input  logic                   mac_overflow,
  output logic                   y_we,
  output logic [RAW-1:0]         y_addr,
  output logic signed [15:0]     y_data,
  output logic                   y_ovf,
  output logic                   ovf_any,
  output logic [1:0]             dbg_state
);

  localparam int WCW = RAW + 1;

  if (NUM_S < 1 || NUM_S > 6) begin : g_bad_num_s
    $error("mac_seq_ctrl: NUM_S must be 1..6");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [RAW-1:0] row_q, row_d;
  logic [VAW-1:0] col_q, col_d;
  logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
  logic           vin_q, vin_d;
  logic           row_ovf_q, row_ovf_d;
  logic           ovf_any_q, ovf_any_d;
  logic           active;
  logic           last_issue;
  logic           last_write;

  // Strobes carry no backpressure: mac_valid_in marks one element per cycle and
  // mac_valid_out one finished row; each is consumed in the cycle it is high.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    wr_cnt_d   = wr_cnt_q;
    row_ovf_d  = row_ovf_q;
    ovf_any_d  = ovf_any_q;
    vin_d      = (state_q == S_ISSUE);
    active     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    last_issue = (row_q == RAW'(NUM_ROWS - 1)) && (col_q == VAW'(VEC_S - 1));
    y_we       = active && mac_valid_out;
    y_ovf      = y_we && (row_ovf_q || mac_overflow);
    last_write = y_we && (wr_cnt_q == WCW'(NUM_ROWS - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_ISSUE;
          row_d     = '0;
          col_d     = '0;
          wr_cnt_d  = '0;
          row_ovf_d = 1'b0;
          ovf_any_d = 1'b0;
        end
      end
      S_ISSUE: begin
        // Counters freeze on the last element so the addresses hold afterwards.
        if (last_issue) begin
          state_d = S_DRAIN;
        end else if (col_q == VAW'(VEC_S - 1)) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (last_write || (wr_cnt_q == WCW'(NUM_ROWS))) begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (y_we) begin
      wr_cnt_d  = wr_cnt_q + 1'b1;
      row_ovf_d = 1'b0;
      if (y_ovf) begin
        ovf_any_d = 1'b1;
      end
    end else if (active && mac_overflow) begin
      row_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      wr_cnt_q  <= '0;
      vin_q     <= 1'b0;
      row_ovf_q <= 1'b0;
      ovf_any_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      wr_cnt_q  <= wr_cnt_d;
      vin_q     <= vin_d;
      row_ovf_q <= row_ovf_d;
      ovf_any_q <= ovf_any_d;
    end
  end

  assign m_addr       = MAW'(row_q) * MAW'(VEC_S) + MAW'(col_q);
  assign v_addr       = col_q;
  assign bias_addr    = row_q;
  assign mac_a        = m_data;
  assign mac_b        = v_data;
  assign mac_x        = bias_data;
  assign mac_valid_in = vin_q;
  assign y_addr       = wr_cnt_q[RAW-1:0];
  assign y_data       = mac_f;
  assign ovf_any      = ovf_any_q;
  assign busy         = active;
  assign done         = (state_q == S_FIN);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: two lanes (NUM_S=1 and NUM_S=4) run the same jobs against
// behavioural memories and a behavioural MAC; writes and done pulses are scoreboarded.
module tb_mac_seq_ctrl;

  localparam int VEC_S    = 4;
  localparam int NUM_ROWS = 2;
  localparam int MAW      = 3;
  localparam int VAW      = 2;
  localparam int RAW      = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic inj = 1'b0;

  logic [1:0]           busy, done, mac_valid_in, mac_valid_out, mac_overflow;
  logic [1:0]           y_we, y_ovf, ovf_any;
  logic [1:0][MAW-1:0]  m_addr;
  logic [1:0][VAW-1:0]  v_addr;
  logic [1:0][RAW-1:0]  bias_addr, y_addr;
  logic [1:0][7:0]      mac_a, mac_b, mac_x;
  logic [1:0][15:0]     mac_f, y_data;
  logic [1:0][1:0]      dbg_state;

  logic [7:0] mat  [8];
  logic [7:0] vec  [4];
  logic [7:0] bias [2];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  // {y_addr, y_ovf, y_data, cycle}
  logic [49:0] exp_q [2][$];
  // {ovf_any, cycle}
  logic [32:0] done_q [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int NS = (g == 0) ? 1 : 4;
    localparam int D  = NS + 2;

    logic signed [7:0]  m_data_q, v_data_q;
    logic [7:0]         bias_data_q;
    logic signed [15:0] acc_q;
    int                 ecnt_q;
    logic [17:0]        pipe_q [D];
    int                 base, sum;
    logic               step_ovf;

    mac_seq_ctrl #(.NUM_S(NS), .VEC_S(VEC_S), .NUM_ROWS(NUM_ROWS)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .busy         (busy[g]),
      .done         (done[g]),
      .m_addr       (m_addr[g]),
      .m_data       (m_data_q),
      .v_addr       (v_addr[g]),
      .v_data       (v_data_q),
      .bias_addr    (bias_addr[g]),
      .bias_data    (bias_data_q),
      .mac_a        (mac_a[g]),
      .mac_b        (mac_b[g]),
      .mac_x        (mac_x[g]),
      .mac_valid_in (mac_valid_in[g]),
      .mac_f        (mac_f[g]),
      .mac_valid_out(mac_valid_out[g]),
      .mac_overflow (mac_overflow[g]),
      .y_we         (y_we[g]),
      .y_addr       (y_addr[g]),
      .y_data       (y_data[g]),
      .y_ovf        (y_ovf[g]),
      .ovf_any      (ovf_any[g]),
      .dbg_state    (dbg_state[g])
    );

    always @(posedge clk) begin
      m_data_q    <= mat[m_addr[g]];
      v_data_q    <= vec[v_addr[g]];
      bias_data_q <= bias[bias_addr[g]];
    end

    // Behavioural MAC: acc starts at bias, adds a*b per element, wraps at 16 bits.
    always_comb begin
      base     = (ecnt_q == 0) ? int'({8'b0, mac_x[g]}) : int'(acc_q);
      sum      = base + int'($signed(mac_a[g])) * int'($signed(mac_b[g]));
      step_ovf = (sum > 32767) || (sum < -32768);
    end

    always @(posedge clk) begin
      if (reset) begin
        acc_q  <= '0;
        ecnt_q <= 0;
        for (int i = 0; i < D; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= {mac_valid_in[g] && (ecnt_q == VEC_S - 1), mac_valid_in[g] && step_ovf, sum[15:0]};
        for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
        if (mac_valid_in[g]) begin
          acc_q  <= sum[15:0];
          ecnt_q <= (ecnt_q == VEC_S - 1) ? 0 : ecnt_q + 1;
        end
      end
    end

    assign mac_valid_out[g] = pipe_q[D-1][17] | ((g == 0) ? inj : 1'b0);
    assign mac_overflow[g]  = pipe_q[D-1][16];
    assign mac_f[g]         = pipe_q[D-1][15:0];
  end

  task automatic chk(input string name, input int l, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s lane%0d: got %0h, expected %0h (cycle %0d)", name, l, act, req, cyc);
  endtask

  task automatic check_zero(input string tag);
    for (int l = 0; l < 2; l++) begin
      chk({tag, "_busy"}, l, 32'(busy[l]), 32'd0);
      chk({tag, "_done"}, l, 32'(done[l]), 32'd0);
      chk({tag, "_mac_valid_in"}, l, 32'(mac_valid_in[l]), 32'd0);
      chk({tag, "_y_we"}, l, 32'(y_we[l]), 32'd0);
      chk({tag, "_y_ovf"}, l, 32'(y_ovf[l]), 32'd0);
      chk({tag, "_ovf_any"}, l, 32'(ovf_any[l]), 32'd0);
      chk({tag, "_m_addr"}, l, 32'(m_addr[l]), 32'd0);
      chk({tag, "_v_addr"}, l, 32'(v_addr[l]), 32'd0);
      chk({tag, "_bias_addr"}, l, 32'(bias_addr[l]), 32'd0);
      chk({tag, "_state"}, l, 32'(dbg_state[l]), 32'd0);
    end
  endtask

  task automatic load_job(input int job);
    case (job)
      0: begin
        mat  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
        vec  = '{8'd1, 8'd1, 8'd1, 8'd1};
        bias = '{8'd5, 8'd10};
      end
      1: begin
        mat  = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'd1, 8'd2, 8'd3, 8'd4};
        vec  = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        bias = '{8'd0, 8'd0};
      end
      default: begin
        mat  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'h7F, 8'h7F, 8'h7F};
        vec  = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
        bias = '{8'd0, 8'd0};
      end
    endcase
  endtask

  task automatic run_job(input int job, input logic [15:0] y0, input logic [15:0] y1,
                         input logic o0, input logic o1, input int restart_at, input int reset_at);
    int t;
    load_job(job);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    for (int l = 0; l < 2; l++) begin
      int ns;
      ns = (l == 0) ? 1 : 4;
      exp_q[l].push_back({1'b0, o0, y0, 32'(t + 7 + ns)});
      exp_q[l].push_back({1'b1, o1, y1, 32'(t + 11 + ns)});
      done_q[l].push_back({o0 | o1, 32'(t + 12 + ns)});
    end
    @(negedge clk);
    start = 1'b0;
    for (int l = 0; l < 2; l++) begin
      chk("busy_after_start", l, 32'(busy[l]), 32'd1);
      chk("ovf_any_cleared", l, 32'(ovf_any[l]), 32'd0);
      chk("m_addr_first", l, 32'(m_addr[l]), 32'd0);
    end
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk);
      if (reset) begin
        check_zero("after_reset");
        reset = 1'b0;
      end
      start = (k == restart_at);
      if (k == reset_at) begin
        reset = 1'b1;
        for (int l = 0; l < 2; l++) begin
          exp_q[l].delete();
          done_q[l].delete();
        end
      end
    end
    start = 1'b0;
    for (int l = 0; l < 2; l++) begin
      chk("writes_outstanding", l, 32'(exp_q[l].size()), 32'd0);
      chk("done_outstanding", l, 32'(done_q[l].size()), 32'd0);
      chk("busy_idle", l, 32'(busy[l]), 32'd0);
      chk("ovf_any_hold", l, 32'(ovf_any[l]), (reset_at > 0) ? 32'd0 : 32'(o0 | o1));
    end
  endtask

  initial begin
    logic [49:0] e;
    logic [32:0] d;
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
        if (y_we[l]) begin
          if (exp_q[l].size() == 0) begin
            chk("y_we_unexpected", l, 32'(y_we[l]), 32'd0);
          end else begin
            e = exp_q[l].pop_front();
            chk("y_addr", l, 32'(y_addr[l]), 32'(e[49]));
            chk("y_ovf", l, 32'(y_ovf[l]), 32'(e[48]));
            chk("y_data", l, 32'(y_data[l]), 32'(e[47:32]));
            chk("y_cycle", l, 32'(cyc), e[31:0]);
          end
        end
        if (done[l]) begin
          if (done_q[l].size() == 0) begin
            chk("done_unexpected", l, 32'(done[l]), 32'd0);
          end else begin
            d = done_q[l].pop_front();
            chk("done_cycle", l, 32'(cyc), d[31:0]);
            chk("done_ovf_any", l, 32'(ovf_any[l]), 32'(d[32]));
            chk("done_busy", l, 32'(busy[l]), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    load_job(0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    run_job(0, 16'd15, 16'd0, 1'b0, 1'b0, 0, 0);
    run_job(1, 16'hFC04, 16'd1270, 1'b1, 1'b0, 0, 0);
    run_job(2, 16'd1270, 16'hBD03, 1'b0, 1'b1, 0, 0);
    run_job(0, 16'd15, 16'd0, 1'b0, 1'b0, 3, 0);
    run_job(0, 16'd15, 16'd0, 1'b0, 1'b0, 0, 5);

    @(negedge clk);
    inj = 1'b1;
    #1;
    chk("y_we_idle_inject", 0, 32'(y_we[0]), 32'd0);
    chk("state_idle_inject", 0, 32'(dbg_state[0]), 32'd0);
    @(negedge clk);
    inj = 1'b0;

    run_job(0, 16'd15, 16'd0, 1'b0, 1'b0, 0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
